// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//
// Game-flow controller for the pong pipeline. Walks the match through
// menu -> serve pause -> live play -> game over, keeps both players' scores,
// and drives the ball hold / re-centre controls. Runs in the pixel clock
// domain; the state and score outputs feed the text-overlay stage.
//
// Parameters
//   WIN_SCORE     score that ends the match (1..15)
//   SERVE_FRAMES  frames the ball is held after each point / at match start
//   OVER_FRAMES   frames spent in game over before returning to the menu
//
// Ports
//   clk            pixel clock
//   rst            synchronous, active-high reset
//   start_btn      start button (synchronised, debounced level)
//   vblnk          vertical blank; its rising edge is the frame tick
//   p1_point       one-cycle pulse, player 1 scored
//   p2_point       one-cycle pulse, player 2 scored
//   state          00 MENU_START, 01 GAME, 10 GAME_OVER
//   player1_score  player 1 score
//   player2_score  player 2 score
//   ball_hold      1 = ball frozen at centre
//   ball_reset     one-cycle pulse, re-centre ball
//   serve_dir      0 = launch toward player 1, 1 = toward player 2
//
// Internal states
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_MENU  | waiting for start press; last match's scores still displayed
//   S_SERVE | ball held at centre, counting frames until launch
//   S_PLAY  | ball live, waiting for a point event
//   S_OVER  | match won, scores frozen, counting frames back to the menu
// ---------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       vblnk,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [1:0] state,
    output logic [3:0] player1_score,
    output logic [3:0] player2_score,
    output logic       ball_hold,
    output logic       ball_reset,
    output logic       serve_dir
);

    localparam logic [1:0] ST_MENU_START = 2'b00;
    localparam logic [1:0] ST_GAME       = 2'b01;
    localparam logic [1:0] ST_GAME_OVER  = 2'b10;

    localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);
    localparam logic [9:0] SERVE_N = 10'(SERVE_FRAMES);
    localparam logic [9:0] OVER_N  = 10'(OVER_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        S_MENU,
        S_SERVE,
        S_PLAY,
        S_OVER
    } fsm_t;

    fsm_t       fsm;
    logic       start_prev;
    logic       vblnk_prev;
    logic [9:0] cnt_frame;

    logic       start_edge;
    logic       frame_tick;
    logic [9:0] cnt_inc;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;

    assign start_edge = start_btn & ~start_prev;
    assign frame_tick = vblnk & ~vblnk_prev;

    // Saturating increment; the timeout compares use the post-increment
    // value so the Nth frame tick is the one that ends the wait.
    assign cnt_inc = (cnt_frame == CNT_MAX) ? cnt_frame : cnt_frame + 10'd1;

    // Scores are capped by WIN_SCORE (<= 15), so these never wrap.
    assign p1_inc = player1_score + 4'd1;
    assign p2_inc = player2_score + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= S_MENU;
            state         <= ST_MENU_START;
            player1_score <= 4'd0;
            player2_score <= 4'd0;
            ball_hold     <= 1'b1;
            ball_reset    <= 1'b0;
            serve_dir     <= 1'b0;
            cnt_frame     <= 10'd0;
            start_prev    <= 1'b0;
            vblnk_prev    <= 1'b0;
        end else begin
            start_prev <= start_btn;
            vblnk_prev <= vblnk;
            ball_reset <= 1'b0;

            case (fsm)
                S_MENU: begin
                    ball_hold <= 1'b1;
                    if (start_edge) begin
                        player1_score <= 4'd0;
                        player2_score <= 4'd0;
                        serve_dir     <= 1'b0;
                        cnt_frame     <= 10'd0;
                        ball_reset    <= 1'b1;
                        fsm           <= S_SERVE;
                        state         <= ST_GAME;
                    end
                end

                // Point events and start presses are deliberately ignored
                // while the ball is being held for the serve.
                S_SERVE: begin
                    if (frame_tick) begin
                        if (cnt_inc == SERVE_N) begin
                            cnt_frame <= 10'd0;
                            ball_hold <= 1'b0;
                            fsm       <= S_PLAY;
                        end else begin
                            cnt_frame <= cnt_inc;
                        end
                    end
                end

                // Simultaneous points cancel out: neither side is credited.
                S_PLAY: begin
                    if (p1_point && !p2_point) begin
                        player1_score <= p1_inc;
                        serve_dir     <= 1'b1;
                        ball_reset    <= 1'b1;
                        ball_hold     <= 1'b1;
                        cnt_frame     <= 10'd0;
                        if (p1_inc == WIN_S) begin
                            fsm   <= S_OVER;
                            state <= ST_GAME_OVER;
                        end else begin
                            fsm <= S_SERVE;
                        end
                    end else if (p2_point && !p1_point) begin
                        player2_score <= p2_inc;
                        serve_dir     <= 1'b0;
                        ball_reset    <= 1'b1;
                        ball_hold     <= 1'b1;
                        cnt_frame     <= 10'd0;
                        if (p2_inc == WIN_S) begin
                            fsm   <= S_OVER;
                            state <= ST_GAME_OVER;
                        end else begin
                            fsm <= S_SERVE;
                        end
                    end
                end

                // Scores stay frozen here and through the menu so the
                // overlay can keep showing the final result.
                S_OVER: begin
                    ball_hold <= 1'b1;
                    if (start_edge || (frame_tick && cnt_inc == OVER_N)) begin
                        cnt_frame <= 10'd0;
                        fsm       <= S_MENU;
                        state     <= ST_MENU_START;
                    end else if (frame_tick) begin
                        cnt_frame <= cnt_inc;
                    end
                end

                default: begin
                    fsm       <= S_MENU;
                    state     <= ST_MENU_START;
                    ball_hold <= 1'b1;
                    cnt_frame <= 10'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

    localparam int WIN   = 3;
    localparam int SERVE = 60;
    localparam int OVERF = 5;

    localparam int P_MENU  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       vblnk = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic [1:0] state;
    logic [3:0] player1_score;
    logic [3:0] player2_score;
    logic       ball_hold;
    logic       ball_reset;
    logic       serve_dir;

    int checks = 0;
    int errors = 0;

    game_state_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_FRAMES(SERVE),
        .OVER_FRAMES (OVERF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .vblnk        (vblnk),
        .p1_point     (p1_point),
        .p2_point     (p2_point),
        .state        (state),
        .player1_score(player1_score),
        .player2_score(player2_score),
        .ball_hold    (ball_hold),
        .ball_reset   (ball_reset),
        .serve_dir    (serve_dir)
    );

    always #5 clk = ~clk;

    // Reference model: match phase, frames remaining in the current wait,
    // and the scoreboard; updated from the inputs the DUT samples.
    int         m_phase = P_MENU;
    int         m_left = 0;
    logic [3:0] m_s1 = 4'd0;
    logic [3:0] m_s2 = 4'd0;
    logic       m_dir = 1'b0;
    logic       m_rpulse = 1'b0;
    logic       m_sp = 1'b0;
    logic       m_vp = 1'b0;

    task automatic model_update();
        logic se;
        logic tk;
        if (rst) begin
            m_phase = P_MENU; m_left = 0; m_s1 = 0; m_s2 = 0;
            m_dir = 0; m_rpulse = 0; m_sp = 0; m_vp = 0;
            return;
        end
        se = start_btn && !m_sp;
        tk = vblnk && !m_vp;
        m_sp = start_btn;
        m_vp = vblnk;
        m_rpulse = 1'b0;
        case (m_phase)
            P_MENU: if (se) begin
                m_s1 = 0; m_s2 = 0; m_dir = 0; m_rpulse = 1;
                m_phase = P_SERVE; m_left = SERVE;
            end
            P_SERVE: if (tk) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = P_PLAY;
            end
            P_PLAY: if (p1_point != p2_point) begin
                if (p1_point) begin m_s1 = m_s1 + 1; m_dir = 1; end
                else          begin m_s2 = m_s2 + 1; m_dir = 0; end
                m_rpulse = 1;
                if (int'(m_s1) == WIN || int'(m_s2) == WIN) begin
                    m_phase = P_OVER; m_left = OVERF;
                end else begin
                    m_phase = P_SERVE; m_left = SERVE;
                end
            end
            default: begin
                if (se) m_phase = P_MENU;
                else if (tk) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = P_MENU;
                end
            end
        endcase
    endtask

    function automatic logic [12:0] model_vec();
        logic [1:0] st;
        st = (m_phase == P_MENU) ? 2'b00 : (m_phase == P_OVER) ? 2'b10 : 2'b01;
        return {st, m_s1, m_s2, (m_phase != P_PLAY), m_rpulse, m_dir};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {state, player1_score, player2_score, ball_hold, ball_reset, serve_dir};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: model advances on the inputs now applied, DUT samples them
    // on the edge, outputs are compared 1 time unit later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL model got=%h expected=%h (st,s1,s2,hold,rst,dir) at %0t",
                     dut_vec(), model_vec(), $time);
        end
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            vblnk = 1'b1; step();
            vblnk = 1'b0; step();
        end
    endtask

    task automatic point(input logic a, input logic b);
        p1_point = a; p2_point = b;
        step();
        p1_point = 1'b0; p2_point = 1'b0;
    endtask

    typedef struct {
        logic       r, s, v, a, b;
        logic [1:0] st;
        logic [3:0] s1, s2;
        logic       hold, rpl, dir;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int trans;
        int pulses;
        int hold_bad;
        logic [1:0] prev_st;

        tbl[0]  = '{1,0,0,0,0, 2'b00, 0, 0, 1, 0, 0};
        tbl[1]  = '{1,1,1,1,0, 2'b00, 0, 0, 1, 0, 0};
        tbl[2]  = '{0,0,0,0,0, 2'b00, 0, 0, 1, 0, 0};
        tbl[3]  = '{0,0,0,1,0, 2'b00, 0, 0, 1, 0, 0};
        tbl[4]  = '{0,0,1,0,1, 2'b00, 0, 0, 1, 0, 0};
        tbl[5]  = '{0,0,0,0,0, 2'b00, 0, 0, 1, 0, 0};
        tbl[6]  = '{0,1,0,0,0, 2'b01, 0, 0, 1, 1, 0};
        tbl[7]  = '{0,1,0,0,0, 2'b01, 0, 0, 1, 0, 0};
        tbl[8]  = '{0,0,0,0,0, 2'b01, 0, 0, 1, 0, 0};
        tbl[9]  = '{0,1,0,1,0, 2'b01, 0, 0, 1, 0, 0};
        tbl[10] = '{0,0,1,0,0, 2'b01, 0, 0, 1, 0, 0};
        tbl[11] = '{0,0,0,0,1, 2'b01, 0, 0, 1, 0, 0};

        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].r; start_btn = tbl[i].s; vblnk = tbl[i].v;
            p1_point = tbl[i].a; p2_point = tbl[i].b;
            step();
            checks++;
            if (dut_vec() !== {tbl[i].st, tbl[i].s1, tbl[i].s2, tbl[i].hold, tbl[i].rpl, tbl[i].dir}) begin
                errors++;
                $display("FAIL table[%0d] got=%h expected=%h", i, dut_vec(),
                         {tbl[i].st, tbl[i].s1, tbl[i].s2, tbl[i].hold, tbl[i].rpl, tbl[i].dir});
            end
        end
        p1_point = 0; p2_point = 0; vblnk = 0; start_btn = 0;

        // Match start with the button held for 100 cycles.
        rst = 1; step(); rst = 0; step();
        chk("reset_state", state, 0);
        chk("reset_hold", ball_hold, 1);
        trans = 0; pulses = 0; hold_bad = 0;
        prev_st = state;
        start_btn = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (prev_st == 2'b00 && state == 2'b01) trans++;
            if (ball_reset) pulses++;
            if (!ball_hold) hold_bad++;
            prev_st = state;
        end
        chk("start_transitions", trans, 1);
        chk("start_reset_pulses", pulses, 1);
        chk("start_hold_low_cycles", hold_bad, 0);
        frame_ticks(SERVE - 1);
        chk("serve_hold_before_last", ball_hold, 1);
        frame_ticks(1);
        chk("serve_hold_after_last", ball_hold, 0);
        chk("serve_no_retrigger", state, 1);
        start_btn = 0; step();

        // Point to player 1, then points during the serve pause.
        point(1, 0);
        chk("p1_score", player1_score, 1);
        chk("p1_dir", serve_dir, 1);
        chk("p1_ball_reset", ball_reset, 1);
        chk("p1_hold", ball_hold, 1);
        step();
        chk("p1_ball_reset_end", ball_reset, 0);
        frame_ticks(SERVE - 1);
        point(1, 0); step(); point(0, 1); step();
        chk("serve_ignore_p1", player1_score, 1);
        chk("serve_ignore_p2", player2_score, 0);
        chk("serve_still_hold", ball_hold, 1);
        frame_ticks(1);
        chk("serve2_hold_released", ball_hold, 0);

        // Simultaneous points in play.
        point(1, 1);
        chk("simul_s1", player1_score, 1);
        chk("simul_s2", player2_score, 0);
        chk("simul_state", state, 1);
        chk("simul_hold", ball_hold, 0);
        chk("simul_no_reset", ball_reset, 0);

        // Score 1/2 then reset mid-play.
        point(0, 1);
        chk("p2_dir", serve_dir, 0);
        frame_ticks(SERVE);
        point(0, 1);
        frame_ticks(SERVE);
        chk("pre_reset_s2", player2_score, 2);
        rst = 1; step();
        chk("mid_rst_vec", dut_vec(), 13'b00_0000_0000_1_0_0);
        step(); rst = 0; step();

        // Win condition: player 1 scores once, player 2 three times.
        start_btn = 1; step(); start_btn = 0; step();
        frame_ticks(SERVE);
        point(1, 0); frame_ticks(SERVE);
        point(0, 1); frame_ticks(SERVE);
        point(0, 1); frame_ticks(SERVE);
        point(0, 1);
        chk("win_state", state, 2);
        chk("win_s2", player2_score, WIN);
        chk("win_s1", player1_score, 1);
        chk("win_ball_reset", ball_reset, 1);
        chk("win_hold", ball_hold, 1);
        point(1, 0); point(0, 1); step();
        chk("over_ignore_s1", player1_score, 1);
        chk("over_ignore_s2", player2_score, WIN);

        // Automatic exit after OVER_FRAMES ticks.
        frame_ticks(OVERF - 1);
        chk("over_before_last", state, 2);
        vblnk = 1; step();
        chk("over_exit_state", state, 0);
        vblnk = 0; step();
        chk("menu_keeps_s1", player1_score, 1);
        chk("menu_keeps_s2", player2_score, WIN);

        // New match, win again, exit by button at frame 2.
        start_btn = 1; step();
        chk("restart_state", state, 1);
        chk("restart_scores", {player1_score, player2_score}, 0);
        start_btn = 0; step();
        frame_ticks(SERVE);
        point(0, 1); frame_ticks(SERVE);
        point(0, 1); frame_ticks(SERVE);
        point(0, 1);
        chk("win2_state", state, 2);
        frame_ticks(2);
        start_btn = 1; step();
        chk("over_btn_exit", state, 0);
        chk("over_btn_s2", player2_score, WIN);
        start_btn = 0; step();
        start_btn = 1; step();
        chk("final_start_state", state, 1);
        chk("final_start_scores", {player1_score, player2_score}, 0);
        start_btn = 0; step();

        // Randomised run against the model.
        for (int i = 0; i < 20000; i++) begin
            rst       = ($urandom_range(4999) == 0);
            if ($urandom_range(15) == 0) start_btn = ~start_btn;
            vblnk     = $urandom_range(1);
            p1_point  = ($urandom_range(19) == 0);
            p2_point  = ($urandom_range(19) == 0);
            step();
            if (errors > 20) break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
